framebuffer_write_ctrl: RTL

FRAMEBUFFER_WRITE_CTRL -- requirements
Module: framebuffer_write_ctrl

---
 rtl/framebuffer_pkg.sv | 32 +++
 rtl/framebuffer_write_ctrl_if.sv | 49 ++++
 rtl/rr_arbiter2.sv | 43 ++++
 rtl/framebuffer_write_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/framebuffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : framebuffer_pkg
//  Description : Shared definitions for the framebuffer write controller:
//                FSM state encoding, default geometry and a port-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package framebuffer_pkg;

    // Default framebuffer geometry.
    localparam int unsigned c_default_height   = 512;
    localparam int unsigned c_default_width    = 1024;
    localparam int unsigned c_default_width_in = 4;

    // Controller states: arbitrating requesters, or streaming a full fill.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fb_state_e;

    // Plain-vector copies of the state encoding for the state register.
    localparam logic [0:0] c_st_idle = ST_IDLE;
    localparam logic [0:0] c_st_fill = ST_FILL;

    // Bits needed to index n items; never less than one so a degenerate
    // dimension still yields a legal vector.
    function automatic int unsigned fb_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : framebuffer_pkg
`default_nettype wire

// File: rtl/framebuffer_write_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : framebuffer_write_ctrl_if
//  Description : Bus bundle for the framebuffer write controller.
//                Requester side : req_valid/req_ready/req_x/req_y/req_data
//                Fill control   : fill_start/fill_data/fill_busy/fill_done
//                Write port     : fb_enable/fb_x/fb_y/fb_data
//                Modport slave is the controller, master is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface framebuffer_write_ctrl_if
    import framebuffer_pkg::*;
#(
    parameter int unsigned HEIGHT   = c_default_height,
    parameter int unsigned WIDTH    = c_default_width,
    parameter int unsigned WIDTH_IN = c_default_width_in
) ();

    localparam int unsigned c_xw = fb_bits(WIDTH);
    localparam int unsigned c_yw = fb_bits(HEIGHT);

    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    logic [1:0][c_xw-1:0]         req_x;
    logic [1:0][c_yw-1:0]         req_y;
    logic [1:0][WIDTH_IN-1:0]     req_data;

    logic                         fill_start;
    logic [WIDTH_IN-1:0]          fill_data;
    logic                         fill_busy;
    logic                         fill_done;

    logic                         fb_enable;
    logic [c_xw-1:0]              fb_x;
    logic [c_yw-1:0]              fb_y;
    logic [WIDTH_IN-1:0]          fb_data;

    modport slave (
        input  req_valid, req_x, req_y, req_data, fill_start, fill_data,
        output req_ready, fill_busy, fill_done, fb_enable, fb_x, fb_y, fb_data
    );

    modport master (
        output req_valid, req_x, req_y, req_data, fill_start, fill_data,
        input  req_ready, fill_busy, fill_done, fb_enable, fb_x, fb_y, fb_data
    );

endinterface : framebuffer_write_ctrl_if
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter with a one-hot combinational
//                grant. The last-granted pointer advances only on accept.
//  Ports       : clk, rst_n  - clock, asynchronous active-low reset
//                i_req[1:0]  - request vector (already qualified by caller)
//                i_accept    - the current grant was taken this cycle
//                o_grant[1:0]- one-hot grant, zero when nothing requests
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // 1 when requester 1 was granted last; resets to 1 so requester 0 wins
    // the first tie.
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_grant[1];
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/framebuffer_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : framebuffer_write_ctrl
//  Description : Framebuffer write-port controller. In IDLE two requesters
//                are arbitrated round-robin onto a registered write port; a
//                fill_start pulse instead streams one fill word to every
//                word location of the buffer, raster order, one per cycle.
//  Ports       : clk          - clock (write-port domain)
//                rst_n        - asynchronous active-low reset
//                bus (slave)  - requester, fill-control and write-port bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_write_ctrl
    import framebuffer_pkg::*;
#(
    parameter int unsigned HEIGHT   = c_default_height,
    parameter int unsigned WIDTH    = c_default_width,
    parameter int unsigned WIDTH_IN = c_default_width_in
) (
    input  logic                      clk,
    input  logic                      rst_n,
    framebuffer_write_ctrl_if.slave   bus
);

    localparam int unsigned     c_xw     = fb_bits(WIDTH);
    localparam int unsigned     c_yw     = fb_bits(HEIGHT);
    localparam logic [c_xw-1:0] c_x_step = c_xw'(WIDTH_IN);
    localparam logic [c_xw-1:0] c_x_last = c_xw'(WIDTH - WIDTH_IN);
    localparam logic [c_yw-1:0] c_y_last = c_yw'(HEIGHT - 1);

    logic [0:0]          r_state;
    logic [c_xw-1:0]     r_cnt_x;      // coordinates of the next fill word
    logic [c_yw-1:0]     r_cnt_y;
    logic [WIDTH_IN-1:0] r_fill_data;

    logic                r_fb_enable;
    logic [c_xw-1:0]     r_fb_x;
    logic [c_yw-1:0]     r_fb_y;
    logic [WIDTH_IN-1:0] r_fb_data;
    logic                r_fill_busy;
    logic                r_fill_done;

    logic                w_idle;
    logic                w_fill_go;
    logic                w_arb_en;
    logic                w_fill_issue;
    logic                w_accept;
    logic                w_sel;
    logic                w_last;
    logic [1:0]          w_grant;
    logic [c_xw-1:0]     w_cur_x;
    logic [c_yw-1:0]     w_cur_y;
    logic [WIDTH_IN-1:0] w_cur_data;

    assign w_idle    = (r_state == c_st_idle);
    assign w_fill_go = w_idle && bus.fill_start;
    // Reset is folded in so req_ready stays low while rst_n is asserted.
    assign w_arb_en  = rst_n && w_idle && !bus.fill_start;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (bus.req_valid & {2{w_arb_en}}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign bus.req_ready = w_grant;
    assign w_accept      = |(bus.req_valid & w_grant);
    assign w_sel         = w_grant[1];

    // The fill word issued this cycle: the fill_start cycle itself issues
    // (0,0) with the incoming fill_data, so the first write is not delayed.
    assign w_fill_issue = w_fill_go || (r_state == c_st_fill);
    assign w_cur_x      = w_fill_go ? '0 : r_cnt_x;
    assign w_cur_y      = w_fill_go ? '0 : r_cnt_y;
    assign w_cur_data   = w_fill_go ? bus.fill_data : r_fill_data;
    assign w_last       = (w_cur_x == c_x_last) && (w_cur_y == c_y_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_cnt_x     <= '0;
            r_cnt_y     <= '0;
            r_fill_data <= '0;
            r_fb_enable <= 1'b0;
            r_fb_x      <= '0;
            r_fb_y      <= '0;
            r_fb_data   <= '0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
        end else if (w_fill_issue) begin
            r_fb_enable <= 1'b1;
            r_fb_x      <= w_cur_x;
            r_fb_y      <= w_cur_y;
            r_fb_data   <= w_cur_data;
            r_fill_busy <= 1'b1;
            r_fill_done <= w_last;
            // Leaving FILL while issuing the final word lets a requester be
            // accepted in the very cycle that word is visible.
            r_state     <= w_last ? c_st_idle : c_st_fill;
            if (w_fill_go) begin
                r_fill_data <= bus.fill_data;
            end
            if (w_cur_x == c_x_last) begin
                r_cnt_x <= '0;
                r_cnt_y <= w_cur_y + 1'b1;
            end else begin
                r_cnt_x <= w_cur_x + c_x_step;
                r_cnt_y <= w_cur_y;
            end
        end else if (w_accept) begin
            r_fb_enable <= 1'b1;
            r_fb_x      <= bus.req_x[w_sel];
            r_fb_y      <= bus.req_y[w_sel];
            r_fb_data   <= bus.req_data[w_sel];
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
        end else begin
            r_fb_enable <= 1'b0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
        end
    end

    assign bus.fb_enable = r_fb_enable;
    assign bus.fb_x      = r_fb_x;
    assign bus.fb_y      = r_fb_y;
    assign bus.fb_data   = r_fb_data;
    assign bus.fill_busy = r_fill_busy;
    assign bus.fill_done = r_fill_done;

endmodule : framebuffer_write_ctrl
`default_nettype wire
